dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl_pkg.sv | 65 ++++++
 rtl/dmem_lane.sv | 53 +++++
 rtl/dmem_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory controller: FSM states, memory-op encodings,
// the issue packet from the LSQ and the CDB broadcast record.
package dmem_ctrl_pkg;

    localparam int XLEN      = 32;
    localparam int ROB_TAG_W = 4;

    localparam logic LS_LOAD  = 1'b0;
    localparam logic LS_STORE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } dmem_state_e;

    // Bit 2 marks the unsigned load variants; stores only use B/H/W.
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_op_e;

    typedef struct packed {
        logic [63:0]     order;
        logic [XLEN-1:0] insn;
        logic [XLEN-1:0] pc_rdata;
        logic [XLEN-1:0] mem_addr;
        logic [3:0]      mem_rmask;
        logic [3:0]      mem_wmask;
        logic [XLEN-1:0] mem_rdata;
        logic [XLEN-1:0] mem_wdata;
    } rvfi_t;

    typedef struct packed {
        logic                 valid;
        mem_op_e              mem_op;
        logic                 ls;
        logic [XLEN-1:0]      rs1_v;
        logic [XLEN-1:0]      rs2_v;
        logic [XLEN-1:0]      offset;
        logic [ROB_TAG_W-1:0] rob_tag;
        rvfi_t                rvfi;
    } fu_pkt_t;

    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [XLEN-1:0]      data;
        rvfi_t                rvfi;
    } cdb_t;

    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] lo);
        case (op)
            MEM_H, MEM_HU: return lo[0];
            MEM_W:         return lo != 2'b00;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering: access masks, store-data shift and load extraction/extension.
// Purely combinational, no state and no backpressure.
module dmem_lane
    import dmem_ctrl_pkg::*;
(
    input  mem_op_e     mem_op,
    input  logic        ls,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] rs2_v,
    output logic [3:0]  rmask,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [3:0]  mask;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        mask = 4'b0000;
        case (mem_op)
            MEM_B, MEM_BU: mask = 4'b0001 << addr_lo;
            MEM_H, MEM_HU: mask = 4'b0011 << addr_lo;
            MEM_W:         mask = 4'b1111;
            default:       mask = 4'b0000;
        endcase
    end

    assign rmask = (ls == LS_LOAD)  ? mask : 4'b0000;
    assign wmask = (ls == LS_STORE) ? mask : 4'b0000;
    assign wdata = rs2_v << {addr_lo, 3'b000};

    // Halves are only ever extracted from aligned offsets 0 or 2.
    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        load_data = 32'h0;
        if (ls == LS_LOAD) begin
            case (mem_op)
                MEM_B:   load_data = {{24{byte_sel[7]}}, byte_sel};
                MEM_BU:  load_data = {24'h0, byte_sel};
                MEM_H:   load_data = {{16{half_sel[15]}}, half_sel};
                MEM_HU:  load_data = {16'h0, half_sel};
                MEM_W:   load_data = rdata;
                default: load_data = 32'h0;
            endcase
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-outstanding data-memory controller: accept op, issue one request, wait, broadcast on CDB.
// Latency 2 cycles + memory delay to cdb_req; backpressure high whenever not idle.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  fu_pkt_t     mem_pkt,
    output logic        backpressure,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        cdb_req,
    input  logic        cdb_gnt,
    output cdb_t        cdb_out
);

    dmem_state_e state_q, state_d;

    mem_op_e              op_q;
    logic                 ls_q;
    logic                 mis_q;
    logic [31:0]          addr_q;
    logic [31:0]          rs2_q;
    logic [ROB_TAG_W-1:0] tag_q;
    rvfi_t                rvfi_q;
    logic [31:0]          data_q;
    logic [31:0]          rdata_q;

    logic [31:0] pkt_addr;
    logic        pkt_mis;
    logic        accept;
    logic        resp_take;

    logic [3:0]  lane_rmask;
    logic [3:0]  lane_wmask;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;

    assign pkt_addr  = mem_pkt.rs1_v + mem_pkt.offset;
    assign pkt_mis   = is_misaligned(mem_pkt.mem_op, pkt_addr[1:0]);
    assign accept    = (state_q == ST_IDLE) && mem_pkt.valid && !flush;
    assign resp_take = (state_q == ST_WAIT) && dmem_resp && !flush;

    dmem_lane u_lane (
        .mem_op    (op_q),
        .ls        (ls_q),
        .addr_lo   (addr_q[1:0]),
        .rdata     (dmem_rdata),
        .rs2_v     (rs2_q),
        .rmask     (lane_rmask),
        .wmask     (lane_wmask),
        .wdata     (lane_wdata),
        .load_data (lane_load)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_pkt.valid && !flush) begin
                    state_d = pkt_mis ? ST_HOLD : ST_REQ;
                end
            end
            // The request has already gone out, so a flush here must still drain its response.
            ST_REQ: state_d = flush ? ST_DRAIN : ST_WAIT;
            ST_WAIT: begin
                if (flush) begin
                    state_d = dmem_resp ? ST_IDLE : ST_DRAIN;
                end else if (dmem_resp) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (flush || cdb_gnt) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (dmem_resp) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= MEM_B;
            ls_q    <= 1'b0;
            mis_q   <= 1'b0;
            addr_q  <= 32'h0;
            rs2_q   <= 32'h0;
            tag_q   <= '0;
            rvfi_q  <= '0;
            data_q  <= 32'h0;
            rdata_q <= 32'h0;
        end else if (accept) begin
            op_q    <= mem_pkt.mem_op;
            ls_q    <= mem_pkt.ls;
            mis_q   <= pkt_mis;
            addr_q  <= pkt_addr;
            rs2_q   <= mem_pkt.rs2_v;
            tag_q   <= mem_pkt.rob_tag;
            rvfi_q  <= mem_pkt.rvfi;
            data_q  <= 32'h0;
            rdata_q <= 32'h0;
        end else if (resp_take) begin
            data_q  <= lane_load;
            rdata_q <= (ls_q == LS_LOAD) ? dmem_rdata : 32'h0;
        end
    end

    always_comb begin
        backpressure = (state_q != ST_IDLE);
        cdb_req      = (state_q == ST_HOLD);

        dmem_addr  = 32'h0;
        dmem_rmask = 4'b0000;
        dmem_wmask = 4'b0000;
        dmem_wdata = 32'h0;
        if (state_q == ST_REQ) begin
            dmem_addr  = {addr_q[31:2], 2'b00};
            dmem_rmask = lane_rmask;
            dmem_wmask = lane_wmask;
            dmem_wdata = lane_wdata;
        end

        // Everything on the CDB is driven from latched state, so it holds steady until granted.
        cdb_out = '0;
        if (state_q == ST_HOLD) begin
            cdb_out.valid          = 1'b1;
            cdb_out.rob_tag        = tag_q;
            cdb_out.data           = data_q;
            cdb_out.rvfi           = rvfi_q;
            cdb_out.rvfi.mem_addr  = {addr_q[31:2], 2'b00};
            cdb_out.rvfi.mem_rmask = mis_q ? 4'b0000 : lane_rmask;
            cdb_out.rvfi.mem_wmask = mis_q ? 4'b0000 : lane_wmask;
            cdb_out.rvfi.mem_rdata = rdata_q;
            cdb_out.rvfi.mem_wdata = (ls_q == LS_STORE && !mis_q) ? lane_wdata : 32'h0;
        end
    end

endmodule
